// File: rtl/encoder_pkg.sv
// Shared types and helpers for the scanning priority encoder family.
// Consumers: prio_encoder and encoder_scan (optional ENCODER_SCAN_COUNT_EN lives in the top).
package encoder_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Widest vector the helpers handle; narrower vectors are zero-extended.
  localparam int ENC_MAX_W = 64;

  // Isolates the first set bit of vec, lowest first or highest first.
  function automatic logic [ENC_MAX_W-1:0] onehot_first(input logic [ENC_MAX_W-1:0] vec,
                                                        input logic msb_first);
    logic [ENC_MAX_W-1:0] r;
    r = '0;
    if (!msb_first) begin
      r = vec & (~vec + ENC_MAX_W'(1));
    end else begin
      for (int i = 0; i < ENC_MAX_W; i++) begin
        if (vec[i]) r = ENC_MAX_W'(1) << i;
      end
    end
    return r;
  endfunction

  // Ceiling log2 used to size index outputs.
  function automatic int idx_width(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_encoder.sv
// Combinational IN_W-to-IDX_W priority encoder with selectable search direction.
// Also returns the isolated winning bit so callers can clear it.
module prio_encoder
  import encoder_pkg::*;
#(
  parameter int IN_W = 16,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W = idx_width(IN_W)
) (
  input  logic [IN_W-1:0]  vec_i,
  output logic [IN_W-1:0]  oh_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [ENC_MAX_W-1:0] oh_full;

  assign oh_full = onehot_first(ENC_MAX_W'(vec_i), MSB_FIRST);
  assign oh_o    = oh_full[IN_W-1:0];

  // Bits above IN_W are always zero, so scanning the full width is harmless.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < ENC_MAX_W; i++) begin
      if (oh_full[i]) idx_o = idx_o | IDX_W'(i);
    end
  end

endmodule

// File: rtl/encoder_scan.sv
// Accepts a request vector and emits the index of every set bit, one per beat.
// Optional macro ENCODER_SCAN_COUNT_EN adds out_count (popcount of the accepted vector).
module encoder_scan
  import encoder_pkg::*;
#(
  parameter int IN_W = 16,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W = idx_width(IN_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero,
  output logic             busy
`ifdef ENCODER_SCAN_COUNT_EN
  ,
  output logic [IDX_W:0]   out_count
`endif
);

  // Both handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and in_ready is the only combinational output.

  state_t            state_q, state_d;
  logic [IN_W-1:0]   pend_q, pend_d;
  logic              zero_q, zero_d;
  logic [IN_W-1:0]   enc_oh;
  logic [IDX_W-1:0]  enc_idx;
  logic              in_scan;
  logic              at_most_one;
  logic              beat;
  logic              accept;

  prio_encoder #(
    .IN_W      (IN_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio (
    .vec_i (pend_q),
    .oh_o  (enc_oh),
    .idx_o (enc_idx)
  );

  assign in_scan     = (state_q == ST_SCAN);
  assign at_most_one = ((pend_q & (pend_q - IN_W'(1))) == '0);

  assign out_valid = in_scan && enable;
  assign out_idx   = in_scan ? enc_idx : '0;
  assign out_last  = in_scan && at_most_one;
  assign out_zero  = in_scan && zero_q;
  assign busy      = in_scan;

  assign beat     = out_valid && out_ready;
  assign in_ready = enable && !reset && (!in_scan || (beat && out_last));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = zero_q;
    // A new vector on the final beat reloads pend and keeps scanning without a bubble.
    if (accept) begin
      pend_d  = in_vec;
      zero_d  = (in_vec == '0);
      state_d = ST_SCAN;
    end else if (beat) begin
      pend_d = pend_q & ~enc_oh;
      if (out_last) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
    end
  end

`ifdef ENCODER_SCAN_COUNT_EN
  logic [IDX_W:0] count_q, count_d, popcnt;

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < IN_W; i++) begin
      popcnt = popcnt + (IDX_W + 1)'(in_vec[i]);
    end
    count_d = accept ? popcnt : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign out_count = count_q;
`endif

endmodule
